// File: rtl/packet_sequencer_pkg.sv
// ============================================================================
// Module      : packet_sequencer_pkg
// Description : Shared types, constants and helpers for the UART packet builder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package packet_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_start_char = 8'h73;

    function automatic int pkt_len(input int num_ch, input int digits,
                                   input int num_cfg, input int cksum);
        return 1 + num_ch * digits + num_cfg + cksum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/packet_byte_mux.sv
// ============================================================================
// Module      : packet_byte_mux
// Description : Combinational select of the packet byte at a given index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_byte_mux
    import packet_sequencer_pkg::*;
#(
    parameter int         NUM_CH      = 2,
    parameter int         DIGITS      = 4,
    parameter int         NUM_CFG     = 4,
    parameter logic [7:0] START_CHAR  = c_start_char,
    parameter int         CHECKSUM_EN = 0,
    parameter int         IDX_W       = 4
) (
    input  logic [IDX_W-1:0]            i_idx,
    input  logic [NUM_CH*DIGITS*8-1:0]  i_digits,
    input  logic [NUM_CFG*8-1:0]        i_cfg,
    input  logic [7:0]                  i_cksum,
    output logic [7:0]                  o_byte
);

    localparam int c_num_dig = NUM_CH * DIGITS;
    localparam int c_pkt_len = pkt_len(NUM_CH, DIGITS, NUM_CFG, CHECKSUM_EN);

    always_comb begin
        o_byte = 8'h00;
        if (i_idx == '0) begin
            o_byte = START_CHAR;
        end
        for (int i = 0; i < c_num_dig; i++) begin
            if (i_idx == IDX_W'(i + 1)) begin
                o_byte = i_digits[i*8 +: 8];
            end
        end
        for (int k = 0; k < NUM_CFG; k++) begin
            if (i_idx == IDX_W'(1 + c_num_dig + k)) begin
                o_byte = i_cfg[k*8 +: 8];
            end
        end
        if ((CHECKSUM_EN != 0) && (i_idx == IDX_W'(c_pkt_len - 1))) begin
            o_byte = i_cksum;
        end
    end

endmodule

`default_nettype wire

// File: rtl/packet_sequencer.sv
// ============================================================================
// Module      : packet_sequencer
// Description : Snapshots channel digits/config and streams a framed packet
//               over a valid/ready byte interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_sequencer
    import packet_sequencer_pkg::*;
#(
    parameter int         NUM_CH      = 2,
    parameter int         DIGITS      = 4,
    parameter int         NUM_CFG     = 4,
    parameter logic [7:0] START_CHAR  = c_start_char,
    parameter int         CHECKSUM_EN = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        send_req,
    input  logic [NUM_CH*DIGITS*8-1:0]  ch_digits,
    input  logic [NUM_CFG*8-1:0]        cfg_bytes,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic                        pkt_done,
    output logic                        req_dropped
);

    localparam int c_pkt_len = pkt_len(NUM_CH, DIGITS, NUM_CFG, CHECKSUM_EN);
    localparam int c_idx_w   = (c_pkt_len > 1) ? $clog2(c_pkt_len) : 1;
    localparam int c_dig_w   = NUM_CH * DIGITS * 8;
    localparam int c_cfg_w   = NUM_CFG * 8;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_idx_w-1:0]     r_idx;
    logic [c_idx_w-1:0]     w_idx_nxt;
    logic [c_dig_w-1:0]     r_digits;
    logic [c_cfg_w-1:0]     r_cfg;
    logic [7:0]             r_cksum;
    logic [7:0]             w_cksum_nxt;
    logic                   w_capture;
    logic                   w_last;
    logic [7:0]             w_byte;
    logic [7:0]             r_tx_data;
    logic                   r_tx_valid;
    logic                   r_busy;
    logic                   r_pkt_done;
    logic                   r_req_dropped;

    assign w_last = (r_idx == c_idx_w'(c_pkt_len - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cksum_nxt = r_cksum;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (send_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SEND;
                    w_idx_nxt   = '0;
                    w_cksum_nxt = 8'h00;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    // The start byte is excluded from the checksum.
                    if (r_idx != '0) begin
                        w_cksum_nxt = r_cksum ^ r_tx_data;
                    end
                    if (w_last) begin
                        w_state_nxt = DONE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = r_idx + c_idx_w'(1);
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Looks ahead at the next index so tx_data can be a registered output.
    packet_byte_mux #(
        .NUM_CH      (NUM_CH),
        .DIGITS      (DIGITS),
        .NUM_CFG     (NUM_CFG),
        .START_CHAR  (START_CHAR),
        .CHECKSUM_EN (CHECKSUM_EN),
        .IDX_W       (c_idx_w)
    ) u_byte_mux (
        .i_idx    (w_idx_nxt),
        .i_digits (r_digits),
        .i_cfg    (r_cfg),
        .i_cksum  (w_cksum_nxt),
        .o_byte   (w_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_digits      <= '0;
            r_cfg         <= '0;
            r_cksum       <= 8'h00;
            r_tx_data     <= 8'h00;
            r_tx_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_pkt_done    <= 1'b0;
            r_req_dropped <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_cksum       <= w_cksum_nxt;
            if (w_capture) begin
                r_digits  <= ch_digits;
                r_cfg     <= cfg_bytes;
            end
            r_tx_valid    <= (w_state_nxt == SEND);
            r_tx_data     <= (w_state_nxt == SEND) ? w_byte : 8'h00;
            r_busy        <= (w_state_nxt != IDLE);
            r_pkt_done    <= (w_state_nxt == DONE);
            r_req_dropped <= send_req && (r_state != IDLE);
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign busy        = r_busy;
    assign pkt_done    = r_pkt_done;
    assign req_dropped = r_req_dropped;

endmodule

`default_nettype wire

// File: tb/tb_packet_sequencer.sv
// ============================================================================
// Module      : tb_packet_sequencer
// Description : Scoreboard bench for packet_sequencer (default and checksum builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_packet_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        send_req_a = 1'b0;
    logic        tx_ready_a = 1'b1;
    logic [63:0] ch_a;
    logic [31:0] cfg_a;
    logic [7:0]  tx_data_a;
    logic        tx_valid_a, busy_a, pkt_done_a, req_dropped_a;

    logic        send_req_b = 1'b0;
    logic        tx_ready_b = 1'b1;
    logic [15:0] ch_b;
    logic [7:0]  cfg_b;
    logic [7:0]  tx_data_b;
    logic        tx_valid_b, busy_b, pkt_done_b, req_dropped_b;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];

    logic [7:0]  exp_a[13] = '{8'h73, 8'h31, 8'h32, 8'h33, 8'h34, 8'h30, 8'h35,
                               8'h36, 8'h37, 8'h03, 8'h05, 8'h07, 8'h01};
    logic [7:0]  exp_b[5]  = '{8'h73, 8'h31, 8'h32, 8'h04, 8'h07};

    always #5 clk = ~clk;

    packet_sequencer u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .send_req    (send_req_a),
        .ch_digits   (ch_a),
        .cfg_bytes   (cfg_a),
        .tx_data     (tx_data_a),
        .tx_valid    (tx_valid_a),
        .tx_ready    (tx_ready_a),
        .busy        (busy_a),
        .pkt_done    (pkt_done_a),
        .req_dropped (req_dropped_a)
    );

    packet_sequencer #(
        .NUM_CH      (1),
        .DIGITS      (2),
        .NUM_CFG     (1),
        .CHECKSUM_EN (1)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .send_req    (send_req_b),
        .ch_digits   (ch_b),
        .cfg_bytes   (cfg_b),
        .tx_data     (tx_data_b),
        .tx_valid    (tx_valid_b),
        .tx_ready    (tx_ready_b),
        .busy        (busy_b),
        .pkt_done    (pkt_done_b),
        .req_dropped (req_dropped_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboard on every handshake and check stall stability.
    logic       prev_stall_a = 1'b0;
    logic [7:0] prev_data_a  = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall_a <= 1'b0;
        end else begin
            if (prev_stall_a) begin
                chk("A stall valid", 32'(tx_valid_a), 32'd1);
                chk("A stall data", 32'(tx_data_a), 32'(prev_data_a));
            end
            if (tx_valid_a && tx_ready_a) begin
                if (q_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL A unexpected byte: got %0h expected none", tx_data_a);
                end else begin
                    chk("A byte", 32'(tx_data_a), 32'(q_a.pop_front()));
                end
            end
            prev_stall_a <= tx_valid_a && !tx_ready_a;
            prev_data_a  <= tx_data_a;
        end
    end

    logic       prev_stall_b = 1'b0;
    logic [7:0] prev_data_b  = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall_b <= 1'b0;
        end else begin
            if (prev_stall_b) begin
                chk("B stall valid", 32'(tx_valid_b), 32'd1);
                chk("B stall data", 32'(tx_data_b), 32'(prev_data_b));
            end
            if (tx_valid_b && tx_ready_b) begin
                if (q_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL B unexpected byte: got %0h expected none", tx_data_b);
                end else begin
                    chk("B byte", 32'(tx_data_b), 32'(q_b.pop_front()));
                end
            end
            prev_stall_b <= tx_valid_b && !tx_ready_b;
            prev_data_b  <= tx_data_b;
        end
    end

    task automatic push_exp(input bit sel);
        if (sel) foreach (exp_b[i]) q_b.push_back(exp_b[i]);
        else     foreach (exp_a[i]) q_a.push_back(exp_a[i]);
    endtask

    task automatic start(input bit sel);
        @(posedge clk); #1;
        if (sel) send_req_b = 1'b1; else send_req_a = 1'b1;
        @(posedge clk); #1;
        send_req_a = 1'b0;
        send_req_b = 1'b0;
        chk("start busy",  32'(sel ? busy_b : busy_a), 32'd1);
        chk("start valid", 32'(sel ? tx_valid_b : tx_valid_a), 32'd1);
        chk("start data",  32'(sel ? tx_data_b : tx_data_a), 32'h73);
    endtask

    task automatic wait_done(input bit sel, input bit bp, output int cycles);
        cycles = 0;
        while (1) begin
            @(posedge clk); #1;
            cycles++;
            if (sel ? pkt_done_b : pkt_done_a) break;
            if (cycles > 500) begin
                checks++;
                failures++;
                $display("FAIL pkt_done timeout: got none expected pulse within 500 cycles");
                break;
            end
            if (bp) begin
                if (sel) tx_ready_b = 1'($urandom_range(0, 1));
                else     tx_ready_a = 1'($urandom_range(0, 1));
            end
        end
        tx_ready_a = 1'b1;
        tx_ready_b = 1'b1;
    endtask

    task automatic finish_pkt(input bit sel);
        chk("done pulse", 32'(sel ? pkt_done_b : pkt_done_a), 32'd1);
        chk("done valid", 32'(sel ? tx_valid_b : tx_valid_a), 32'd0);
        chk("done busy",  32'(sel ? busy_b : busy_a), 32'd1);
        @(posedge clk); #1;
        chk("idle busy",  32'(sel ? busy_b : busy_a), 32'd0);
        chk("idle done",  32'(sel ? pkt_done_b : pkt_done_a), 32'd0);
        chk("queue empty", sel ? q_b.size() : q_a.size(), 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        ch_a  = {8'h37, 8'h36, 8'h35, 8'h30, 8'h34, 8'h33, 8'h32, 8'h31};
        cfg_a = {8'h01, 8'h07, 8'h05, 8'h03};
        ch_b  = {8'h32, 8'h31};
        cfg_b = 8'h04;

        repeat (3) @(posedge clk);
        #1;
        chk("reset valid",   32'(tx_valid_a), 32'd0);
        chk("reset data",    32'(tx_data_a), 32'h00);
        chk("reset busy",    32'(busy_a), 32'd0);
        chk("reset done",    32'(pkt_done_a), 32'd0);
        chk("reset dropped", 32'(req_dropped_a), 32'd0);
        chk("reset B valid", 32'(tx_valid_b), 32'd0);
        rst_n = 1'b1;

        // Plain packet, ready held high
        push_exp(0);
        start(0);
        wait_done(0, 0, cyc);
        chk("A cycles in SEND", cyc, 32'd13);
        finish_pkt(0);

        // Random backpressure
        push_exp(0);
        start(0);
        wait_done(0, 1, cyc);
        finish_pkt(0);

        // Inputs change right after capture
        push_exp(0);
        start(0);
        ch_a = {8{8'h39}};
        wait_done(0, 1, cyc);
        finish_pkt(0);
        ch_a = {8'h37, 8'h36, 8'h35, 8'h30, 8'h34, 8'h33, 8'h32, 8'h31};

        // Checksum build, ready high then backpressure
        push_exp(1);
        start(1);
        wait_done(1, 0, cyc);
        chk("B cycles in SEND", cyc, 32'd5);
        finish_pkt(1);
        push_exp(1);
        start(1);
        wait_done(1, 1, cyc);
        finish_pkt(1);

        // Collisions during byte 3 and during the pkt_done cycle
        push_exp(0);
        start(0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        send_req_a = 1'b1;
        @(posedge clk); #1;
        send_req_a = 1'b0;
        chk("drop mid-packet", 32'(req_dropped_a), 32'd1);
        wait_done(0, 0, cyc);
        send_req_a = 1'b1;
        @(posedge clk); #1;
        send_req_a = 1'b0;
        chk("drop in done", 32'(req_dropped_a), 32'd1);
        chk("drop busy",    32'(busy_a), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (tx_valid_a || req_dropped_a) seen = 1'b1;
        end
        chk("no second packet", 32'(seen), 32'd0);
        chk("collision queue", q_a.size(), 32'd0);

        // Reset during byte 6
        push_exp(0);
        start(0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort valid",   32'(tx_valid_a), 32'd0);
        chk("abort data",    32'(tx_data_a), 32'h00);
        chk("abort busy",    32'(busy_a), 32'd0);
        chk("abort done",    32'(pkt_done_a), 32'd0);
        chk("abort dropped", 32'(req_dropped_a), 32'd0);
        q_a.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (tx_valid_a || pkt_done_a) seen = 1'b1;
        end
        chk("no resume", 32'(seen), 32'd0);
        push_exp(0);
        start(0);
        wait_done(0, 0, cyc);
        finish_pkt(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/packet_sequencer.md
# packet_sequencer

Parametrised UART packet builder between the measurement/control registers and the UART transmitter. On a send request it snapshots all channel digit bytes and configuration bytes, then streams a framed packet one byte per valid/ready handshake: start character, channel digits, config bytes, and an optional XOR checksum. Default parameters emit the existing 13-byte packet: 's', 2×4 digits, and v_scale/t_scale/trigger/switch. It owns byte sequencing, backpressure and busy/done signalling.

## Interface
- NUM_CH, default 2: number of channels; each contributes DIGITS bytes.
- DIGITS, default 4: ASCII digit bytes per channel, most significant digit first.
- NUM_CFG, default 4: configuration bytes sent after the channels.
- START_CHAR, default 8'h73: frame start byte ('s').
- CHECKSUM_EN, default 0: 1 appends an XOR checksum byte.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- send_req  in  1  single-cycle request to send one packet.
- ch_digits  in  NUM_CH*DIGITS*8  flattened digits; channel c, digit d (d=0 is MSD) at bits [(c*DIGITS+d)*8 +: 8].
- cfg_bytes  in  NUM_CFG*8  config byte k at bits [k*8 +: 8].
- tx_data  out  8  current packet byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART transmitter accepts the byte.
- busy  out  1  packet in progress.
- pkt_done  out  1  one-cycle pulse after the last byte is accepted.
- req_dropped  out  1  one-cycle pulse when send_req arrives while busy.

## Operation
- PKT_LEN = 1 + NUM_CH*DIGITS + NUM_CFG + CHECKSUM_EN. Byte index idx has width $clog2(PKT_LEN).
- Byte order: idx 0 is START_CHAR. idx 1..NUM_CH*DIGITS are the channel digits, channel 0 first. Config bytes follow, cfg 0 first. The checksum is last when enabled.
- States:
  - IDLE: on send_req, capture ch_digits and cfg_bytes into shadow registers, set idx=0, clear the checksum accumulator, and go to SEND.
  - SEND: tx_valid=1 and tx_data=byte[idx] from the shadow registers. On tx_valid&&tx_ready, idx increments. If idx was PKT_LEN-1, go to DONE.
  - DONE: pulse pkt_done for one cycle, then go to IDLE.
- Checksum is the XOR of every byte accepted from idx 1 through the last non-checksum byte. START_CHAR is excluded. The checksum is accumulated on each handshake.
- Input changes after the capture cycle do not affect the packet in flight.
- send_req during SEND or DONE is ignored, with req_dropped pulsed in the next cycle. There is no queuing.
- A tx_ready that is high while tx_valid is low has no effect.

## Timing
- Reset values: tx_valid=0, tx_data=8'h00, busy=0, pkt_done=0, req_dropped=0, state IDLE, idx=0, shadow registers and checksum cleared.
- tx_data, tx_valid, busy, pkt_done and req_dropped are all registered outputs.
- send_req at edge N gives busy=1, tx_valid=1 and tx_data=START_CHAR after edge N.
- With tx_ready held high, one byte is accepted per cycle, so the whole packet takes PKT_LEN cycles in SEND.
- The last byte is accepted at edge M. After edge M: tx_valid=0 and pkt_done=1, with busy still 1.
- After edge M+1: busy=0 and pkt_done=0. Earliest next send_req is accepted at edge M+2.
- tx_data is stable while tx_valid=1 and tx_ready=0. tx_valid never drops without a handshake, except on reset.
- Reset asserted mid-packet aborts at once: tx_valid falls asynchronously, no pkt_done is produced, and the packet is not resumed.

## Structure
- Package packet_sequencer_pkg holds:
  - the state enum typedef (IDLE, SEND, DONE);
  - the default START_CHAR constant;
  - the function pkt_len(num_ch, digits, num_cfg, cksum).
- One combinational sub-module, packet_byte_mux, maps (idx, shadow registers, checksum) to the byte. It is the parametrised replacement of the old fixed character select.
- The top level holds the FSM, idx counter, shadow capture and checksum accumulator.

## Test plan
- Defaults, tx_ready=1:
  - Stimulus: ch0 "1234", ch1 "0567", cfg {8'h03, 8'h05, 8'h07, 8'h01}, one send_req.
  - Response: 13 consecutive bytes 73 31 32 33 34 30 35 36 37 03 05 07 01, then pkt_done one cycle later.
- Backpressure:
  - Stimulus: tx_ready toggles 1-0-0-1 randomly.
  - Response: byte sequence identical to the previous case, tx_data stable during stalls, no byte skipped or repeated.
- Snapshot:
  - Stimulus: change ch_digits to all 8'h39 one cycle after send_req.
  - Response: the packet still carries the captured digits.
- CHECKSUM_EN=1, NUM_CH=1, DIGITS=2, NUM_CFG=1:
  - Stimulus: digits 8'h31 8'h32, cfg 8'h04.
  - Response: bytes 73 31 32 04 07. Checksum 31^32^04=07. PKT_LEN=5.
- Collision:
  - Stimulus: send_req during byte 3, then a second send_req in the pkt_done cycle.
  - Response: both produce req_dropped, and only one packet is sent.
- Reset:
  - Stimulus: assert rst_n=0 during byte 6.
  - Response: tx_valid=0 immediately and all outputs at reset values. After release, a new send_req sends a full packet starting with 8'h73.
